bcd2bin_serial: RTL and testbench

- Multi-digit packed BCD to binary converter; the decimal-to-binary counterpart of the team's hex-to-decimal digit stage.
- Uses a serial reverse double-dabble: one shift/correct step per enabled clock.
- Sits between decimal display/entry logic and binary datapaths.
- Start/busy/done handshake; CE stalls the block, consistent with the existing cascadable stages.

---
 rtl/bcd2bin_serial.sv | 102 ++++++++++
 tb/tb_bcd2bin_serial.sv | 137 +++++++++++++
 2 files changed

// File: rtl/bcd2bin_serial.sv
// Serial packed-BCD to binary converter (reverse double-dabble), one shift/correct
// step per enabled clock, with start/busy/done handshake and clock-enable stall.
module bcd2bin_serial #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  CE,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bin_out,
    output logic                  err
);
    localparam int N  = 4*DIGITS;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t         state, state_nx;
    logic [N-1:0]   b_r, s_r;
    logic [N-1:0]   b_sh, s_sh, b_fix;
    logic [CW-1:0]  cnt;
    logic           err_r;
    logic           bad;
    logic           last;

    always_comb begin
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++)
            if (bcd_in[4*i +: 4] > 4'd9) bad = 1'b1;
    end

    // {B,S} >> 1 with a zero entering the top of B
    assign b_sh = {1'b0, b_r[N-1:1]};
    assign s_sh = {b_r[0], s_r[N-1:1]};

    always_comb begin
        b_fix = b_sh;
        for (int i = 0; i < DIGITS; i++)
            if (b_sh[4*i +: 4] >= 4'd8) b_fix[4*i +: 4] = b_sh[4*i +: 4] - 4'd3;
    end

    assign last = (cnt == CW'(N-1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  state <= IDLE;
        else if (CE) state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = bad ? DONE : SHIFT;
            SHIFT:   if (last)  state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Results are loaded on entry to DONE so they are already valid while done is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_r     <= '0;
            s_r     <= '0;
            cnt     <= '0;
            err_r   <= 1'b0;
            bin_out <= '0;
            err     <= 1'b0;
        end else if (CE) begin
            case (state)
                IDLE: if (start) begin
                    if (bad) begin
                        err_r   <= 1'b1;
                        bin_out <= '0;
                        err     <= 1'b1;
                    end else begin
                        b_r <= bcd_in;
                        s_r <= '0;
                        cnt <= '0;
                    end
                end
                SHIFT: begin
                    b_r <= b_fix;
                    s_r <= s_sh;
                    cnt <= cnt + 1'b1;
                    if (last) begin
                        bin_out <= err_r ? '0 : s_sh;
                        err     <= err_r;
                    end
                end
                DONE:    err_r <= 1'b0;
                default: ;
            endcase
        end
    end

    assign busy = (state == SHIFT);
    assign done = (state == DONE);

endmodule

// File: tb/tb_bcd2bin_serial.sv
// Scoreboard bench for bcd2bin_serial: expected results are queued at start and
// compared when done is seen, along with latency and busy duration.
module tb_bcd2bin_serial;
    logic        clk = 1'b0;
    logic        rst_n, CE, start;
    logic [15:0] bcd_in;
    logic        busy, done, err;
    logic [15:0] bin_out;

    int n_vec = 0;
    int n_bad = 0;
    logic [16:0] exp_q[$];

    bcd2bin_serial #(.DIGITS(4)) dut (
        .clk(clk), .rst_n(rst_n), .CE(CE), .start(start), .bcd_in(bcd_in),
        .busy(busy), .done(done), .bin_out(bin_out), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // {err, binary} from plain decimal arithmetic on the digits
    function automatic logic [16:0] model(input logic [15:0] b);
        int v = 0;
        bit e = 0;
        for (int i = 3; i >= 0; i--) begin
            int d = int'(b[4*i +: 4]);
            if (d > 9) e = 1;
            v = v*10 + d;
        end
        return e ? {1'b1, 16'h0} : {1'b0, v[15:0]};
    endfunction

    task automatic convert(input logic [15:0] bcd, input int stall_at, input int stall_len, input bit poke);
        logic [16:0] e, got;
        int t, exp_t, nbusy;
        bit seen;
        e = model(bcd);
        exp_q.push_back(e);
        exp_t = e[16] ? 1 : 17 + stall_len;
        start = 1'b1; bcd_in = bcd; CE = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; bcd_in = 16'h0;
        t = 1; seen = 0; nbusy = 0;
        while (!seen && t < 80) begin
            CE = !(stall_len > 0 && t >= stall_at && t < stall_at + stall_len);
            if (poke && t == stall_at + stall_len + 2) begin
                start = 1'b1; bcd_in = 16'h1111;
            end else begin
                start = 1'b0; bcd_in = 16'h0;
            end
            @(negedge clk);
            if (busy) nbusy++;
            if (done && CE) begin
                seen = 1;
                chk("latency", 32'(t), 32'(exp_t));
                if (exp_q.size() == 0) chk("sb_empty", 32'd1, 32'd0);
                else begin
                    got = exp_q.pop_front();
                    chk("bin_out", 32'(bin_out), 32'(got[15:0]));
                    chk("err", 32'(err), 32'(got[16]));
                end
            end
            @(posedge clk); #1;
            if (!seen) t++;
        end
        start = 1'b0; bcd_in = 16'h0; CE = 1'b1;
        if (!seen) chk("done_timeout", 32'd0, 32'd1);
        chk("busy_cycles", 32'(nbusy), e[16] ? 32'd0 : 32'(16 + stall_len));
        @(negedge clk);
        chk("done_pulse", 32'({busy, done}), 32'd0);
        chk("hold", 32'(bin_out), 32'(e[15:0]));
        @(posedge clk); #1;
    endtask

    initial begin
        int nd;
        logic [15:0] r;
        rst_n = 1'b0; CE = 1'b1; start = 1'b0; bcd_in = 16'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_bin", 32'(bin_out), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        convert(16'h1234, 0, 0, 0);
        convert(16'h9999, 0, 0, 0);
        convert(16'h0000, 0, 0, 0);
        convert(16'h12A4, 0, 0, 0);
        convert(16'h0042, 0, 0, 0);
        convert(16'h0099, 6, 5, 1);

        // Reset mid-conversion: nothing must come out of the aborted job
        exp_q.push_back(model(16'h5000));
        start = 1'b1; bcd_in = 16'h5000;
        @(posedge clk); #1;
        start = 1'b0; bcd_in = 16'h0;
        repeat (7) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_err", 32'(err), 32'd0);
        chk("abort_bin", 32'(bin_out), 32'd0);
        void'(exp_q.pop_back());
        @(posedge clk); #1;
        rst_n = 1'b1;
        nd = 0;
        repeat (30) begin
            @(negedge clk);
            if (done) nd++;
        end
        chk("no_done_after_rst", 32'(nd), 32'd0);
        @(posedge clk); #1;
        convert(16'h5000, 0, 0, 0);

        for (int k = 0; k < 6; k++) begin
            for (int d = 0; d < 4; d++) r[4*d +: 4] = 4'($urandom_range(0, 9));
            if (k == 5) r[11:8] = 4'($urandom_range(10, 15));
            convert(r, 0, 0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
